// File: rtl/lsu_riscv_if.sv
// Data-memory bus between the load/store unit and data RAM.
//   mem_req   : request, high for every cycle the transaction is outstanding
//   mem_we    : write enable (store)
//   mem_be    : byte enables within the addressed word
//   mem_addr  : word-aligned address
//   mem_wd    : lane-replicated write data
//   mem_rd    : read word from memory
//   mem_ready : acknowledge; completes the outstanding transaction
// master = LSU side, slave = memory side.
interface lsu_riscv_if;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_be,
        output mem_addr,
        output mem_wd,
        input  mem_rd,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_be,
        input  mem_addr,
        input  mem_wd,
        output mem_rd,
        output mem_ready
    );
endinterface

// File: rtl/lsu_riscv.sv
// Load/store unit: turns one core memory op into one data-bus transaction and
// stalls the decoder until the op completes.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   core_req_i          : memory op request from decoder
//   core_we_i           : 1 = store, 0 = load
//   core_size_i         : 0 B, 1 H, 2 W, 4 BU, 5 HU (3/6/7 behave as B)
//   core_addr_i         : byte address
//   core_wd_i           : store data
//   core_rd_o           : registered, extended load result
//   core_stall_req_o    : combinational stall request to decoder
//   misaligned_o        : one-cycle pulse, misaligned op rejected without bus access
//   bus_err_o           : one-cycle pulse, bus timeout abort
//   mem_if              : data-memory bus (master side)
// TIMEOUT_CYCLES: BUSY cycles without ready before abort; 0 disables the timeout.
module lsu_riscv #(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [2:0]         core_size_i,
    input  logic [31:0]        core_addr_i,
    input  logic [31:0]        core_wd_i,
    output logic [31:0]        core_rd_o,
    output logic               core_stall_req_o,
    output logic               misaligned_o,
    output logic               bus_err_o,
    lsu_riscv_if.master        mem_if
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;
    typedef enum logic [1:0] {WidB, WidH, WidW} width_e;

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    width_e      width_q, width_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic [31:0] cnt_q, cnt_d;
    logic        misal_q, misal_d;
    logic        err_q, err_d;

    // Decode of the incoming op.
    width_e      in_width;
    logic        in_uns;
    logic        in_misal;
    logic [3:0]  in_be;
    logic [31:0] in_wd;

    always_comb begin
        in_width = WidB;
        in_uns   = 1'b0;
        case (core_size_i)
            3'd1:    in_width = WidH;
            3'd2:    in_width = WidW;
            3'd4:    in_uns = 1'b1;
            3'd5: begin
                in_width = WidH;
                in_uns   = 1'b1;
            end
            default: ;
        endcase

        in_misal = ((in_width == WidH) && core_addr_i[0]) ||
                   ((in_width == WidW) && (core_addr_i[1:0] != 2'b00));

        case (in_width)
            WidH: begin
                in_be = 4'b0011 << {core_addr_i[1], 1'b0};
                in_wd = {2{core_wd_i[15:0]}};
            end
            WidW: begin
                in_be = 4'hF;
                in_wd = core_wd_i;
            end
            default: begin
                in_be = 4'b0001 << core_addr_i[1:0];
                in_wd = {4{core_wd_i[7:0]}};
            end
        endcase
    end

    // Load extraction uses the latched offset, not the live core address.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    always_comb begin
        case (addr_q[1:0])
            2'd1:    rd_byte = mem_if.mem_rd[15:8];
            2'd2:    rd_byte = mem_if.mem_rd[23:16];
            2'd3:    rd_byte = mem_if.mem_rd[31:24];
            default: rd_byte = mem_if.mem_rd[7:0];
        endcase
        rd_half = addr_q[1] ? mem_if.mem_rd[31:16] : mem_if.mem_rd[15:0];

        case (width_q)
            WidB:    rd_ext = uns_q ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            WidH:    rd_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = mem_if.mem_rd;
        endcase
    end

    always_comb begin
        state_d = state_q;
        width_d = width_q;
        uns_d   = uns_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        cnt_d   = 32'h0;
        misal_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (core_req_i) begin
                    if (in_misal) begin
                        misal_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        width_d = in_width;
                        uns_d   = in_uns;
                        we_d    = core_we_i;
                        addr_d  = core_addr_i;
                        be_d    = in_be;
                        wd_d    = in_wd;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                // Ready wins over a timeout landing in the same cycle.
                if (mem_if.mem_ready) begin
                    if (!we_q) begin
                        rd_d = rd_ext;
                    end
                    state_d = StDone;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // The finished instruction is still presented here; do not reissue it.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            width_q <= WidB;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wd_q    <= 32'h0;
            rd_q    <= 32'h0;
            cnt_q   <= 32'h0;
            misal_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            misal_q <= misal_d;
            err_q   <= err_d;
        end
    end

    assign core_rd_o        = rd_q;
    assign core_stall_req_o = core_req_i & (state_q != StDone);
    assign misaligned_o     = misal_q;
    assign bus_err_o        = err_q;

    assign mem_if.mem_req  = (state_q == StBusy);
    assign mem_if.mem_we   = (state_q == StBusy) & we_q;
    assign mem_if.mem_be   = be_q;
    assign mem_if.mem_addr = {addr_q[31:2], 2'b00};
    assign mem_if.mem_wd   = wd_q;

endmodule

// File: tb/tb_lsu_riscv.sv
module tb_lsu_riscv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [2:0]  core_size = 3'd0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wd = 32'h0;
    logic [31:0] core_rd;
    logic        stall;
    logic        misal;
    logic        berr;

    lsu_riscv_if bus ();

    lsu_riscv #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_req_i       (core_req),
        .core_we_i        (core_we),
        .core_size_i      (core_size),
        .core_addr_i      (core_addr),
        .core_wd_i        (core_wd),
        .core_rd_o        (core_rd),
        .core_stall_req_o (stall),
        .misaligned_o     (misal),
        .bus_err_o        (berr),
        .mem_if           (bus.master)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'h0;

    // Observations collected by do_op for one operation.
    int          o_stall, o_req, o_mis, o_err, o_changes;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wd, o_rd;
    logic        o_we;
    bit          o_done;

    function automatic logic [31:0] model_rd(input logic [2:0] size, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*off +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            3'd2:    return d;
            3'd1:    return {{16{h[15]}}, h};
            3'd5:    return {16'h0, h};
            3'd4:    return {24'h0, b};
            default: return {{24{b[7]}}, b};
        endcase
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd2:       return 4'hF;
            3'd1, 3'd5: return off[1] ? 4'hC : 4'h3;
            default: begin
                case (off)
                    2'd0:    return 4'h1;
                    2'd1:    return 4'h2;
                    2'd2:    return 4'h4;
                    default: return 4'h8;
                endcase
            end
        endcase
    endfunction

    function automatic logic [31:0] model_wd(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            3'd2:       return wd;
            3'd1, 3'd5: return {wd[15:0], wd[15:0]};
            default:    return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        endcase
    endfunction

    function automatic bit model_mis(input logic [2:0] size, input logic [1:0] off);
        return ((size == 3'd1 || size == 3'd5) && off[0]) || (size == 3'd2 && off != 2'd0);
    endfunction

    // Drive one op and play the memory; ready_at = BUSY cycle index of ready (-1 = never).
    task automatic do_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int ready_at);
        int busy_n;
        busy_n = 0;
        o_stall = 0; o_req = 0; o_mis = 0; o_err = 0; o_changes = 0; o_done = 0;
        o_be = 4'h0; o_addr = 32'h0; o_wd = 32'h0; o_we = 1'b0; o_rd = 32'h0;
        @(negedge clk);
        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        bus.mem_rd = rdata; bus.mem_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (misal) o_mis++;
            if (berr) o_err++;
            if (bus.mem_req) begin
                if (o_req > 0 && (bus.mem_be !== o_be || bus.mem_addr !== o_addr ||
                                  bus.mem_wd !== o_wd || bus.mem_we !== o_we))
                    o_changes++;
                o_req++;
                o_be = bus.mem_be; o_addr = bus.mem_addr; o_wd = bus.mem_wd; o_we = bus.mem_we;
                bus.mem_ready = (busy_n == ready_at);
                busy_n++;
            end else begin
                bus.mem_ready = 1'b0;
            end
            if (stall) begin
                o_stall++;
            end else begin
                o_done = 1;
                o_rd = core_rd;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        core_req = 1'b0; bus.mem_ready = 1'b0;
        #1;
        if (misal) o_mis++;
        if (berr) o_err++;
        if (bus.mem_req) o_req++;
    endtask

    task automatic test_reset;
        n_tests++;
        if (core_rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_rd: got %h expected 00000000", core_rd);
        end
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be} !== 6'h0) begin
            n_fail++; $display("FAIL reset_req_we_be: got %b expected 000000",
                               {bus.mem_req, bus.mem_we, bus.mem_be});
        end
        n_tests++;
        if ({bus.mem_addr, bus.mem_wd} !== 64'h0) begin
            n_fail++; $display("FAIL reset_addr_wd: got %h expected 0", {bus.mem_addr, bus.mem_wd});
        end
        n_tests++;
        if ({misal, berr, stall} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 000", {misal, berr, stall});
        end
    endtask

    task automatic test_lw;
        logic [31:0] e;
        exp_q.push_back(32'hDEADBEEF);
        do_op(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        e = exp_q.pop_front();
        last_rd = e;
        n_tests++;
        if (o_rd !== e) begin n_fail++; $display("FAIL lw_rd: got %h expected %h", o_rd, e); end
        n_tests++;
        if (o_be !== 4'hF) begin n_fail++; $display("FAIL lw_be: got %h expected f", o_be); end
        n_tests++;
        if (o_addr !== 32'h100) begin
            n_fail++; $display("FAIL lw_addr: got %h expected 00000100", o_addr);
        end
        n_tests++;
        if (o_stall !== 2) begin n_fail++; $display("FAIL lw_stall: got %0d expected 2", o_stall); end
        n_tests++;
        if (o_req !== 1) begin n_fail++; $display("FAIL lw_req_cycles: got %0d expected 1", o_req); end
    endtask

    task automatic test_lb;
        logic [31:0] e;
        exp_q.push_back(32'hFFFFFF80);
        do_op(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        e = exp_q.pop_front();
        n_tests++;
        if (o_rd !== e) begin n_fail++; $display("FAIL lb_rd: got %h expected %h", o_rd, e); end
        n_tests++;
        if (o_be !== 4'h8) begin n_fail++; $display("FAIL lb_be: got %h expected 8", o_be); end
        exp_q.push_back(32'h00000080);
        do_op(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        e = exp_q.pop_front();
        last_rd = e;
        n_tests++;
        if (o_rd !== e) begin n_fail++; $display("FAIL lbu_rd: got %h expected %h", o_rd, e); end
    endtask

    task automatic test_sh;
        logic [31:0] e;
        exp_q.push_back(last_rd);
        do_op(1'b1, 3'd1, 32'h22, 32'h1234ABCD, 32'h5555AAAA, 2);
        e = exp_q.pop_front();
        n_tests++;
        if (o_be !== 4'hC) begin n_fail++; $display("FAIL sh_be: got %h expected c", o_be); end
        n_tests++;
        if (o_wd !== 32'hABCDABCD) begin
            n_fail++; $display("FAIL sh_wd: got %h expected abcdabcd", o_wd);
        end
        n_tests++;
        if (o_req !== 3 || o_changes !== 0 || o_we !== 1'b1) begin
            n_fail++; $display("FAIL sh_hold: got req=%0d changes=%0d we=%b expected 3 0 1",
                               o_req, o_changes, o_we);
        end
        n_tests++;
        if (o_stall !== 4) begin n_fail++; $display("FAIL sh_stall: got %0d expected 4", o_stall); end
        n_tests++;
        if (o_rd !== e) begin n_fail++; $display("FAIL sh_rd_kept: got %h expected %h", o_rd, e); end
    endtask

    task automatic test_misaligned;
        logic [31:0] e;
        exp_q.push_back(last_rd);
        do_op(1'b0, 3'd2, 32'h101, 32'h0, 32'h11111111, 0);
        e = exp_q.pop_front();
        n_tests++;
        if (o_mis !== 1) begin n_fail++; $display("FAIL mis_pulse: got %0d expected 1", o_mis); end
        n_tests++;
        if (o_req !== 0) begin n_fail++; $display("FAIL mis_no_bus: got %0d expected 0", o_req); end
        n_tests++;
        if (o_stall !== 1) begin n_fail++; $display("FAIL mis_stall: got %0d expected 1", o_stall); end
        n_tests++;
        if (o_rd !== e) begin n_fail++; $display("FAIL mis_rd_kept: got %h expected %h", o_rd, e); end
    endtask

    task automatic test_timeout;
        logic [31:0] e;
        exp_q.push_back(last_rd);
        do_op(1'b0, 3'd2, 32'h300, 32'h0, 32'h22222222, -1);
        e = exp_q.pop_front();
        n_tests++;
        if (o_req !== 4) begin n_fail++; $display("FAIL to_busy_cycles: got %0d expected 4", o_req); end
        n_tests++;
        if (o_err !== 1) begin n_fail++; $display("FAIL to_bus_err: got %0d expected 1", o_err); end
        n_tests++;
        if (o_stall !== 5) begin n_fail++; $display("FAIL to_stall: got %0d expected 5", o_stall); end
        n_tests++;
        if (o_rd !== e) begin n_fail++; $display("FAIL to_rd_kept: got %h expected %h", o_rd, e); end
    endtask

    // Every size code at every byte offset, loads then stores, random data and latency.
    task automatic test_lanes;
        logic [31:0] e, a, d, w;
        logic [2:0]  sz;
        logic [1:0]  off;
        bit          mis;
        for (int we = 0; we < 2; we++) begin
            for (int s = 0; s < 8; s++) begin
                for (int o = 0; o < 4; o++) begin
                    sz = s[2:0]; off = o[1:0];
                    a = $urandom; a[1:0] = off;
                    d = $urandom; w = $urandom;
                    mis = model_mis(sz, off);
                    e = (we == 1 || mis) ? last_rd : model_rd(sz, off, d);
                    exp_q.push_back(e);
                    do_op(we[0], sz, a, w, d, $urandom_range(0, 2));
                    e = exp_q.pop_front();
                    last_rd = e;
                    n_tests++;
                    if (o_rd !== e) begin
                        n_fail++; $display("FAIL lanes_rd we=%0d size=%0d off=%0d: got %h expected %h",
                                           we, s, o, o_rd, e);
                    end
                    if (mis) begin
                        n_tests++;
                        if (o_mis !== 1 || o_req !== 0) begin
                            n_fail++; $display("FAIL lanes_mis size=%0d off=%0d: got mis=%0d req=%0d expected 1 0",
                                               s, o, o_mis, o_req);
                        end
                    end else begin
                        n_tests++;
                        if (o_be !== model_be(sz, off) || o_addr !== {a[31:2], 2'b00}) begin
                            n_fail++; $display("FAIL lanes_be_addr size=%0d off=%0d: got %h %h expected %h %h",
                                               s, o, o_be, o_addr, model_be(sz, off), {a[31:2], 2'b00});
                        end
                        if (we == 1) begin
                            n_tests++;
                            if (o_wd !== model_wd(sz, w)) begin
                                n_fail++; $display("FAIL lanes_wd size=%0d: got %h expected %h",
                                                   s, o_wd, model_wd(sz, w));
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        logic [31:0] data [3] = '{32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(data[i]);
            do_op(1'b0, 3'd2, 32'h400 + 32'(i * 4), 32'h0, data[i], 0);
            e = exp_q.pop_front();
            last_rd = e;
            n_tests++;
            if (o_rd !== e || o_req !== 1) begin
                n_fail++; $display("FAIL b2b_%0d: got rd=%h req=%0d expected %h 1", i, o_rd, o_req, e);
            end
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] e;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h200;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_busy: got %b expected 1", bus.mem_req);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.mem_req !== 1'b0 || core_rd !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_abort: got req=%b rd=%h expected 0 00000000",
                               bus.mem_req, core_rd);
        end
        last_rd = 32'h0;
        core_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(32'h55AA1234);
        do_op(1'b0, 3'd2, 32'h204, 32'h0, 32'h55AA1234, 0);
        e = exp_q.pop_front();
        last_rd = e;
        n_tests++;
        if (o_rd !== e || o_req !== 1 || o_addr !== 32'h204) begin
            n_fail++; $display("FAIL rst_fresh_txn: got rd=%h req=%0d addr=%h expected %h 1 00000204",
                               o_rd, o_req, o_addr, e);
        end
    endtask

    initial begin
        bus.mem_rd = 32'h0;
        bus.mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_lw;
        test_lb;
        test_sh;
        test_misaligned;
        test_timeout;
        test_lanes;
        test_back_to_back;
        test_reset_mid_op;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
